// File: rtl/intersection_ctrl.sv
// Two-way (N/S and E/W) intersection controller with all-red clearance,
// a latched pedestrian walk phase and a flashing-yellow maintenance mode.
// The one-second timebase is derived from clk by a free-running divider.
module intersection_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int GREEN_S       = 5,
  parameter int YELLOW_S      = 3,
  parameter int ALLRED_S      = 1,
  parameter int PED_S         = 4,
  parameter int SEC_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [3:0] phase
);

  localparam int DIV_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(TICKS_PER_SEC - 1);
  // A phase of duration D leaves on the tick where the counter reads D-1.
  localparam logic [SEC_W-1:0] GREEN_END  = SEC_W'(GREEN_S - 1);
  localparam logic [SEC_W-1:0] YELLOW_END = SEC_W'(YELLOW_S - 1);
  localparam logic [SEC_W-1:0] ALLRED_END = SEC_W'(ALLRED_S - 1);
  localparam logic [SEC_W-1:0] PED_END    = SEC_W'(PED_S - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    NS_GREEN  = 4'd1,
    NS_YELLOW = 4'd2,
    ALLRED_A  = 4'd3,
    EW_GREEN  = 4'd4,
    EW_YELLOW = 4'd5,
    ALLRED_B  = 4'd6,
    PED_WALK  = 4'd7,
    FLASH     = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DIV_W-1:0]   r_div;
  logic [SEC_W-1:0]   r_sec;
  logic               r_running;
  logic               r_btn_prev;
  logic               r_flash_on;
  logic               r_ped;
  logic               w_tick;
  logic               w_start_edge;
  logic               w_changing;

  assign w_tick       = (r_div == DIV_MAX);
  assign w_start_edge = start_btn & ~r_btn_prev;
  assign w_changing   = (w_next != r_state);
  assign ped_pending  = r_ped;

  // Timebase divider: free-runs out of reset, independent of run/stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Run/stop toggle on each rising edge of the start button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_prev <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_btn_prev <= start_btn;
      if (w_start_edge) begin
        r_running <= ~r_running;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase counter: restarts on every state change and while stopped or flashing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec <= '0;
    end else if (!r_running || flash_mode || w_changing) begin
      r_sec <= '0;
    end else if (w_tick) begin
      r_sec <= r_sec + SEC_W'(1);
    end
  end

  // Flash blinker: starts lit on FLASH entry, toggles on each tick inside FLASH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_on <= 1'b0;
    end else if (r_state != FLASH && w_next == FLASH) begin
      r_flash_on <= 1'b1;
    end else if (r_state == FLASH && w_tick) begin
      r_flash_on <= ~r_flash_on;
    end
  end

  // Pedestrian latch: a new request beats the clear on PED_WALK entry,
  // so a request held across entry is served on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped <= 1'b0;
    end else if (ped_req && r_running && r_state != FLASH) begin
      r_ped <= 1'b1;
    end else if (w_next == IDLE || (w_next == PED_WALK && r_state != PED_WALK)) begin
      r_ped <= 1'b0;
    end
  end

  // Next-state: stop beats flash, flash beats the normal sequence.
  always_comb begin
    w_next = r_state;
    if (!r_running) begin
      w_next = IDLE;
    end else if (flash_mode) begin
      w_next = FLASH;
    end else begin
      case (r_state)
        IDLE:      w_next = ALLRED_B;
        NS_GREEN:  if (w_tick && r_sec == GREEN_END)  w_next = NS_YELLOW;
        NS_YELLOW: if (w_tick && r_sec == YELLOW_END) w_next = ALLRED_A;
        ALLRED_A:  if (w_tick && r_sec == ALLRED_END) w_next = EW_GREEN;
        EW_GREEN:  if (w_tick && r_sec == GREEN_END)  w_next = EW_YELLOW;
        EW_YELLOW: if (w_tick && r_sec == YELLOW_END) w_next = ALLRED_B;
        ALLRED_B:  if (w_tick && r_sec == ALLRED_END) w_next = r_ped ? PED_WALK : NS_GREEN;
        PED_WALK:  if (w_tick && r_sec == PED_END)    w_next = NS_GREEN;
        FLASH:     w_next = ALLRED_B;
        default:   w_next = IDLE;
      endcase
    end
  end

  // Moore lamp decode: red whenever an approach is neither green nor yellow.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    phase     = r_state;
    case (r_state)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      PED_WALK:  walk = 1'b1;
      FLASH: begin
        ns_red    = 1'b0;
        ew_red    = 1'b0;
        ns_yellow = r_flash_on;
        ew_yellow = r_flash_on;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with a fast timebase (4 clks per tick).
module tb_intersection_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_btn;
  logic       ped_req;
  logic       flash_mode;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk;
  logic       ped_pending;
  logic [3:0] phase;
  logic [6:0] lamps;

  int n_vec  = 0;
  int n_miss = 0;

  // {phase, lamps, dwell in clks}
  logic [18:0] exp_q[$];

  localparam logic [6:0] L_RESET = 7'b1001000;
  localparam logic [6:0] L_PED   = 7'b1001001;
  localparam logic [6:0] L_FLON  = 7'b0100100;
  localparam logic [6:0] L_DARK  = 7'b0000000;

  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  intersection_ctrl #(
    .TICKS_PER_SEC(4),
    .GREEN_S(5),
    .YELLOW_S(3),
    .ALLRED_S(1),
    .PED_S(4),
    .SEC_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_btn(start_btn),
    .ped_req(ped_req),
    .flash_mode(flash_mode),
    .ns_red(ns_red),
    .ns_yellow(ns_yellow),
    .ns_green(ns_green),
    .ew_red(ew_red),
    .ew_yellow(ew_yellow),
    .ew_green(ew_green),
    .walk(walk),
    .ped_pending(ped_pending),
    .phase(phase)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conflicting approaches must never be lit together outside FLASH.
  always @(negedge clk) begin
    if (rst_n && phase != 4'd8) begin
      assert (!((ns_green | ns_yellow) && (ew_green | ew_yellow)))
        else $error("FAIL mutex: ns and ew both active, phase=%0d", phase);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [3:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (phase !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(phase), 32'(target));
  endtask

  // Counts negedges (including the current one) for which phase stays put.
  task automatic measure_phase(output int n);
    logic [3:0] p;
    p = phase;
    n = 0;
    while (phase === p && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic measure_lamps(input logic [6:0] v, output int n);
    n = 0;
    while (lamps === v && n < 16) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  initial begin
    int d;
    logic [18:0] e;
    rst_n      = 1'b0;
    start_btn  = 1'b0;
    ped_req    = 1'b0;
    flash_mode = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_lamps", 32'(lamps), 32'(L_RESET));
    chk("rst_ped", 32'(ped_pending), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start: IDLE -> ALLRED_B one clk after running goes high
    start_btn = 1'b1;
    @(negedge clk);
    chk("start_still_idle", 32'(phase), 32'd0);
    start_btn = 1'b0;
    @(negedge clk);
    chk("start_allred_b", 32'(phase), 32'd6);
    wait_phase(4'd1, 8, "first_ns_green");

    // Full normal cycle, dwell and lamps per phase
    exp_q.push_back({4'd1, 7'b0011000, 8'd20});
    exp_q.push_back({4'd2, 7'b0101000, 8'd12});
    exp_q.push_back({4'd3, 7'b1001000, 8'd4});
    exp_q.push_back({4'd4, 7'b1000010, 8'd20});
    exp_q.push_back({4'd5, 7'b1000100, 8'd12});
    exp_q.push_back({4'd6, 7'b1001000, 8'd4});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("seq_phase", 32'(phase), 32'(e[18:15]));
      chk("seq_lamps", 32'(lamps), 32'(e[14:8]));
      measure_phase(d);
      chk("seq_dwell", 32'(d), 32'(e[7:0]));
    end
    chk("seq_wrap", 32'(phase), 32'd1);

    // One-clk pedestrian request during EW_GREEN
    wait_phase(4'd4, 60, "ped_reach_ew_green");
    pulse_ped();
    chk("ped_latched", 32'(ped_pending), 32'd1);
    wait_phase(4'd7, 60, "ped_walk_entry");
    chk("ped_walk_lamps", 32'(lamps), 32'(L_PED));
    chk("ped_cleared", 32'(ped_pending), 32'd0);
    measure_phase(d);
    chk("ped_walk_dwell", 32'(d), 32'd16);
    chk("ped_then_ns", 32'(phase), 32'd1);

    // Request held across PED_WALK entry is served again next cycle
    wait_phase(4'd4, 60, "hold_reach_ew_green");
    ped_req = 1'b1;
    wait_phase(4'd7, 60, "hold_walk_entry");
    chk("hold_set_wins", 32'(ped_pending), 32'd1);
    ped_req = 1'b0;
    wait_phase(4'd1, 30, "hold_ns_green");
    wait_phase(4'd6, 80, "hold_allred_b");
    measure_phase(d);
    chk("hold_walk_again", 32'(phase), 32'd7);
    chk("hold_cleared", 32'(ped_pending), 32'd0);
    wait_phase(4'd1, 30, "hold_back_ns");

    // Stop during NS_GREEN drops the pending request
    pulse_ped();
    chk("stop_ped_set", 32'(ped_pending), 32'd1);
    start_btn = 1'b1;
    @(negedge clk);
    chk("stop_one_clk", 32'(phase), 32'd1);
    start_btn = 1'b0;
    @(negedge clk);
    chk("stop_idle", 32'(phase), 32'd0);
    chk("stop_lamps", 32'(lamps), 32'(L_RESET));
    chk("stop_ped_clr", 32'(ped_pending), 32'd0);
    pulse_start();
    @(negedge clk);
    chk("restart_allred_b", 32'(phase), 32'd6);
    wait_phase(4'd1, 5, "restart_ns_green");

    // Flash mode raised during EW_YELLOW
    wait_phase(4'd5, 60, "flash_reach_ew_yellow");
    flash_mode = 1'b1;
    @(negedge clk);
    chk("flash_entry", 32'(phase), 32'd8);
    chk("flash_on_lamps", 32'(lamps), 32'(L_FLON));
    measure_lamps(L_FLON, d);
    chk("flash_first_off", 32'(lamps), 32'(L_DARK));
    measure_lamps(L_DARK, d);
    chk("flash_off_dwell", 32'(d), 32'd4);
    chk("flash_relit", 32'(lamps), 32'(L_FLON));
    measure_lamps(L_FLON, d);
    chk("flash_on_dwell", 32'(d), 32'd4);
    chk("flash_still", 32'(phase), 32'd8);
    flash_mode = 1'b0;
    @(negedge clk);
    chk("flash_exit", 32'(phase), 32'd6);
    wait_phase(4'd1, 5, "flash_then_ns");

    // Asynchronous reset in the middle of PED_WALK
    pulse_ped();
    wait_phase(4'd7, 100, "rst_reach_walk");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_lamps", 32'(lamps), 32'(L_RESET));
    chk("arst_ped", 32'(ped_pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Two-way (N/S and E/W) traffic intersection controller. It is the parametrised successor of the single-approach red/green/yellow light.
- It adds parametrised phase durations, all-red clearance intervals, a latched pedestrian walk phase and a flashing-yellow maintenance mode.
- It sits between the board buttons and switches and the six approach LEDs plus a walk LED. The 1 Hz timebase is derived internally from clk.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk cycles per timebase tick (use 4 in simulation).
- GREEN_S, 5, green duration per approach, in ticks (≥1).
- YELLOW_S, 3, yellow duration, in ticks (≥1).
- ALLRED_S, 1, all-red clearance duration, in ticks (≥1).
- PED_S, 4, walk phase duration, in ticks (≥1).
- SEC_W, 8, phase-counter width; every duration must be ≤ 2^SEC_W−1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start_btn  in  1  run/stop toggle; already synchronised and debounced
- ped_req  in  1  pedestrian request; level, sampled every clk
- flash_mode  in  1  maintenance flashing-yellow mode; level
- ns_red, ns_yellow, ns_green  out  1 each  N/S approach lamps
- ew_red, ew_yellow, ew_green  out  1 each  E/W approach lamps
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  a pedestrian request is latched
- phase  out  4  current state code, for debug

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset clears the tick divider, phase counter, running, ped_pending, the button-edge register and flash_on.
  - state=IDLE. Outputs during reset: ns_red=ew_red=1, all other lamps 0, walk=0, phase=0.
- Timebase:
  - Divider counts 0..TICKS_PER_SEC−1 and wraps.
  - tick=1 for the single clk when divider==TICKS_PER_SEC−1.
  - The divider free-runs whenever rst_n is high and is unaffected by run or stop.
- Run control:
  - Rising edge of start_btn (start_btn & ~prev) toggles running.
  - The edge register updates every clk.
- State codes: IDLE=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_A=3, EW_GREEN=4, EW_YELLOW=5, ALLRED_B=6, PED_WALK=7, FLASH=8.
- Phase counter (sec_cnt):
  - Cleared on every state change.
  - Incremented on a tick when the state does not change.
  - A state with duration D exits on the tick where sec_cnt==D−1, so it lasts exactly D ticks after its first tick.
- Normal sequence: ALLRED_B → NS_GREEN(GREEN_S) → NS_YELLOW(YELLOW_S) → ALLRED_A(ALLRED_S) → EW_GREEN(GREEN_S) → EW_YELLOW(YELLOW_S) → ALLRED_B(ALLRED_S).
  - When ALLRED_B expires: go to PED_WALK(PED_S) if ped_pending, otherwise NS_GREEN.
  - PED_WALK → NS_GREEN on expiry.
- IDLE → ALLRED_B on the clk after running becomes 1.
- Priority, evaluated each clk:
  - running==0 → IDLE next clk from any state; sec_cnt cleared.
  - Else flash_mode==1 → FLASH next clk from any state; sec_cnt cleared.
  - Else normal sequence.
- FLASH:
  - flash_on is set to 1 on entry and toggles on each tick.
  - ns_yellow=ew_yellow=flash_on; all other lamps 0; walk=0.
  - flash_mode low → ALLRED_B next clk.
- Pedestrian latch:
  - ped_pending is set on any clk with ped_req=1 && running && state!=FLASH.
  - It is cleared on the clk of entry into PED_WALK. If ped_req=1 on that same clk, set wins; the request is served in the next cycle.
  - Cleared when entering IDLE.
- Output decode, Moore on state:
  - Each approach lights exactly one lamp except in FLASH.
  - Red is lit in every state where that approach is not green or yellow.
  - walk=1 only in PED_WALK; both approaches are red there.
  - phase equals the state code.
- Invariants:
  - Never ns_green|ns_yellow together with ew_green|ew_yellow.
  - An all-red state always sits between the two approaches' green phases.
- Reset mid-phase returns to IDLE immediately. The remaining time is not retained.

Test Plan (TICKS_PER_SEC=4, GREEN_S=5, YELLOW_S=3, ALLRED_S=1, PED_S=4):
- Reset, then pulse start_btn → phase goes 0→6 the next clk. NS_GREEN is entered on the first tick. Phase dwell counts are 20/12/4/20/12/4 clks for phases 1/2/3/4/5/6, and the sequence repeats.
- Pulse ped_req for one clk during EW_GREEN → ped_pending=1. After ALLRED_B, phase=7 for 16 clks with walk=1 and both reds=1. ped_pending=0 from PED_WALK entry, then NS_GREEN.
- Hold ped_req=1 across PED_WALK entry → ped_pending stays 1, and the next cycle inserts PED_WALK again.
- Pulse start_btn during NS_GREEN → IDLE next clk: both reds=1, ped_pending=0. Pulse again → ALLRED_B, then NS_GREEN after 1 tick.
- Raise flash_mode during EW_YELLOW → FLASH next clk with both yellows=1. They toggle every 4 clks, and all reds/greens stay 0. Drop flash_mode → ALLRED_B, then NS_GREEN.
- Assert rst_n=0 mid-PED_WALK → all outputs return to reset values asynchronously. Across all scenarios, an assertion checks the mutual-exclusion invariant.
